// File: rtl/down_counter_timer_pkg.sv
// Shared constants for the down counter / interval timer: FSM state encoding
// and the select codes for the count register's next-value mux.
package counter_pkg;
  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
  localparam logic [ST_W-1:0] ST_RUN  = 2'b01;
  localparam logic [ST_W-1:0] ST_DONE = 2'b10;

  // Count register next-value select
  localparam logic [1:0] CR_HOLD = 2'b00;
  localparam logic [1:0] CR_LOAD = 2'b01;
  localparam logic [1:0] CR_DEC  = 2'b10;
endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle of the down counter timer. The master side (software
// or an FSM) drives commands; the slave side is the timer itself.
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output clear, load, load_val, en, auto_reload,
    input  q, tc, busy, done
  );

  modport slave (
    input  clear, load, load_val, en, auto_reload,
    output q, tc, busy, done
  );
endinterface

// File: rtl/down_counter_timer_count_reg.sv
// WIDTH-bit count register: loads an arbitrary value, decrements by one, or
// holds. Plain unsigned WIDTH-bit arithmetic; the caller never asks it to
// decrement from zero, so it never wraps.
module count_reg
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] q
);

  // Register update selected by the controller's next-value mux code
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      case (sel)
        CR_LOAD: q <= val;
        CR_DEC:  q <= q - WIDTH'(1);
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down counter / interval timer. Counts a loaded period down once per
// enabled cycle, pulses tc for one cycle at terminal count, then either stops
// in DONE (one-shot) or reloads the saved period (periodic).
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  down_counter_timer_if.slave  bus
);

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_nxt;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_nxt;
  logic             tc_nxt;
  logic [1:0]       cr_sel;
  logic [WIDTH-1:0] cr_val;
  logic [WIDTH-1:0] q;

  count_reg #(.WIDTH(WIDTH)) u_count_reg (
    .clk   (clk),
    .reset (reset),
    .sel   (cr_sel),
    .val   (cr_val),
    .q     (q)
  );

  // Next-state decision: clear beats load, load beats counting
  always_comb begin
    state_nxt  = state;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;
    cr_sel     = CR_HOLD;
    cr_val     = '0;
    if (bus.clear) begin
      cr_sel    = CR_LOAD;
      cr_val    = '0;
      state_nxt = ST_IDLE;
    end else if (bus.load) begin
      cr_sel     = CR_LOAD;
      cr_val     = bus.load_val;
      reload_nxt = bus.load_val;
      // A zero period means "do not start"
      state_nxt  = (bus.load_val != '0) ? ST_RUN : ST_IDLE;
    end else if (state == ST_RUN && bus.en) begin
      if (q > WIDTH'(1)) begin
        cr_sel = CR_DEC;
      end else if (q == WIDTH'(1)) begin
        tc_nxt = 1'b1;
        cr_sel = CR_LOAD;
        if (bus.auto_reload) begin
          cr_val = reload_reg;
        end else begin
          cr_val    = '0;
          state_nxt = ST_DONE;
        end
      end
    end
  end

  // FSM state, terminal-count pulse and saved period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bus.tc     <= 1'b0;
      reload_reg <= '0;
    end else begin
      state      <= state_nxt;
      bus.tc     <= tc_nxt;
      reload_reg <= reload_nxt;
    end
  end

  assign bus.q    = q;
  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Testbench for down_counter_timer (WIDTH=4): directed scenarios followed by
// randomized commands, all compared against a behavioural timer model.
module tb_down_counter_timer;
  localparam int WIDTH = 4;

  logic clk;
  logic reset;

  down_counter_timer_if #(.WIDTH(WIDTH)) bus ();

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: remaining count, saved period, running / expired flags
  int m_q;
  int m_period;
  bit m_tc;
  bit m_running;
  bit m_expired;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_period = 0; m_tc = 0; m_running = 0; m_expired = 0;
  endtask

  task automatic model_edge(input bit c, input bit l, input int lv, input bit e, input bit ar);
    m_tc = 0;
    if (c) begin
      m_q = 0; m_running = 0; m_expired = 0;
    end else if (l) begin
      m_period = lv; m_q = lv; m_running = (lv != 0); m_expired = 0;
    end else if (m_running && e) begin
      if (m_q == 1) begin
        m_tc = 1;
        if (ar) m_q = m_period;
        else begin
          m_q = 0; m_running = 0; m_expired = 1;
        end
      end else begin
        m_q = m_q - 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".q"},    int'(bus.q),    m_q);
    check_val({tag, ".tc"},   int'(bus.tc),   int'(m_tc));
    check_val({tag, ".busy"}, int'(bus.busy), int'(m_running));
    check_val({tag, ".done"}, int'(bus.done), int'(m_expired));
  endtask

  // One clock: drive at negedge, model the edge, sample 1 time unit after
  task automatic step(input string tag, input bit c, input bit l, input int lv,
                      input bit e, input bit ar);
    @(negedge clk);
    bus.clear       = c;
    bus.load        = l;
    bus.load_val    = WIDTH'(lv);
    bus.en          = e;
    bus.auto_reload = ar;
    @(posedge clk);
    model_edge(c, l, lv, e, ar);
    #1;
    compare_all(tag);
  endtask

  int tc_count;
  int edges;

  initial begin
    bus.clear = 0; bus.load = 0; bus.load_val = '0; bus.en = 0; bus.auto_reload = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-run
    step("rst_load", 0, 1, 9, 0, 0);
    for (int i = 0; i < 3; i++) step("rst_run", 0, 0, 0, 1, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all("rst_async");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step("rst_after", 0, 0, 0, 1, 0);

    // One-shot
    step("os_load", 0, 1, 3, 1, 0);
    for (int i = 0; i < 6; i++) step("os_run", 0, 0, 0, 1, 0);

    // Periodic
    step("per_load", 0, 1, 5, 1, 1);
    for (int i = 0; i < 12; i++) step("per_run", 0, 0, 0, 1, 1);

    // Enable gating
    step("gate_load", 0, 1, 2, 0, 0);
    step("gate_e1", 0, 0, 0, 1, 0);
    step("gate_e0", 0, 0, 0, 0, 0);
    step("gate_e1b", 0, 0, 0, 1, 0);

    // Load zero never starts
    step("zero_load", 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("zero_run", 0, 0, 0, 1, 0);

    // Max period: tc after exactly 15 enabled edges, no wrap
    step("max_load", 0, 1, 15, 1, 0);
    tc_count = 0;
    edges = 0;
    while (tc_count == 0 && edges < 40) begin
      step("max_run", 0, 0, 0, 1, 0);
      edges++;
      if (bus.tc) tc_count++;
    end
    check_val("max_period", edges, 15);
    step("max_after", 0, 0, 0, 1, 0);

    // Restart mid-run, clear vs load, load from DONE
    step("pri_load", 0, 1, 4, 1, 0);
    step("pri_dec", 0, 0, 0, 1, 0);
    step("pri_dec2", 0, 0, 0, 1, 0);
    check_val("pri_at2", int'(bus.q), 2);
    step("pri_restart", 0, 1, 9, 1, 0);
    step("pri_clr_load", 1, 1, 7, 1, 0);
    step("pri_l1", 0, 1, 1, 1, 0);
    step("pri_exp", 0, 0, 0, 1, 0);
    step("pri_from_done", 0, 1, 6, 1, 0);

    // Randomized commands
    for (int i = 0; i < 600; i++) begin
      step("rand",
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
